cim_mem_arb: RTL
================

Name: cim_mem_arb

Overview:
- Parametrised successor to the CiM single-bank memory wrapper: one single-port storage array shared by N_REQ requesters (bus FSM, logic FSM, MAC, LayerNorm, and later requesters).
- Adds explicit per-requester arbitration with grant feedback, selectable fixed-priority or round-robin policy, per-requester write permission and a tagged one-cycle read return.
- Illegal-access flags replace simulation-only fatal assertions.
- One instance per CiM memory (intermediate results, parameters).

Parameters:
- DATA_W, 16, storage word width in bits.
- DEPTH, 528, number of words; ADDR_W = $clog2(DEPTH).
- N_REQ, 4, number of requesters; index 0 is highest fixed priority.
- RR_EN, 0, 0 = fixed priority, 1 = round-robin.
- WR_MASK, 4'b1011, bit i = 1 means requester i may write (MAC, index 2, read-only by default).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rd_req  in  N_REQ  per-requester read request, level, held until granted.
- wr_req  in  N_REQ  per-requester write request, level, held until granted.
- addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- wr_data  in  N_REQ*DATA_W  packed write data, same packing.
- grant  out  N_REQ  one-hot combinational grant for the current cycle.
- rd_valid  out  1  read data valid, registered.
- rd_id  out  $clog2(N_REQ)  index of the requester that owns rd_data.
- rd_data  out  DATA_W  read data, registered.
- err_illegal_wr  out  1  sticky: a masked requester asserted wr_req.
- err_addr_oob  out  1  sticky: a granted access had addr >= DEPTH.
- err_rw_both  out  1  sticky: one requester asserted rd_req and wr_req in the same cycle.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Request vector: req[i] = (rd_req[i] | (wr_req[i] & WR_MASK[i])).
  - Masked writes never become requests and never modify storage.
- Fixed priority (RR_EN = 0): grant the lowest index with req set.
- Round-robin (RR_EN = 1):
  - Pointer rr_ptr (reset 0). Grant the first req index at or after rr_ptr, wrapping modulo N_REQ.
  - On any grant, rr_ptr <= granted index + 1, wrapping N_REQ-1 to 0.
  - No grant: pointer holds.
- grant is combinational from req and rr_ptr. At most one bit is set. Requesters must hold their request until they see their grant bit.
- Same requester with rd_req and wr_req both set:
  - Treated as a write if WR_MASK permits; otherwise as a read.
  - Sets err_rw_both either way.
- Granted write: mem[addr_i] <= wr_data_i at the posedge. No read return is produced.
- Granted read:
  - rd_data <= mem[addr_i], rd_valid <= 1 and rd_id <= i at the posedge.
  - Latency is 1 cycle from the grant cycle to rd_valid.
  - Back-to-back reads every cycle are supported, including reads from different requesters on consecutive cycles.
- No grant, or granted write: rd_valid <= 0. rd_data and rd_id hold their last value.
- Read and write to the same address in consecutive cycles: the read returns the newly written value (no write-through within the same cycle, since storage is single port).
- Out-of-range address on a granted access: write dropped, read returns 0 with rd_valid = 1, err_addr_oob set.
- Error flags are sticky until rst. Each is set at the posedge following the offending cycle.
- Reset values: rd_valid = 0, rd_id = 0, rd_data = 0, all err_* = 0, rr_ptr = 0. Storage contents are not reset.
- Reset mid-operation: an in-flight read is discarded, so rd_valid is 0 immediately on rst assertion and no stale return appears after release. Any write in the cycle rst is asserted is not performed.

Test Plan:
1. Fixed priority, RR_EN = 0: write 0x1234 to addr 5 via req 0. Next cycle rd_req[3] at addr 5 -> grant = 4'b1000; next cycle rd_valid = 1, rd_id = 3, rd_data = 0x1234.
2. Contention: rd_req = 4'b0110 held for 2 cycles, fixed priority -> grant 0010 then 0100 once req 1 drops. rd_id sequence is 1, 2 on consecutive cycles.
3. Round-robin, RR_EN = 1: rd_req = 4'b1111 held for 8 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001, ... Each requester is granted every 4 cycles.
4. Permissions: wr_req[2] = 1, addr 7, data 0xBEEF -> grant = 0, mem[7] unchanged (a follow-up read returns the prior value), err_illegal_wr = 1 and stays 1 until rst.
5. Boundary: read addr DEPTH-1 after writing 0xFFFF -> 0xFFFF. Read addr DEPTH (if DEPTH < 2^ADDR_W) -> rd_data = 0, err_addr_oob = 1. Simultaneous rd_req[0] and wr_req[0] -> write performed, no rd_valid, err_rw_both = 1.
6. Reset mid-read: grant a read, assert rst before the next posedge -> rd_valid = 0 immediately, all flags 0, rr_ptr = 0. After release, the first grant follows the reset priority order.

Source files
------------

// File: rtl/cim_mem_arb.sv
// cim_mem_arb: single-port storage shared by N_REQ requesters.
// One grant per cycle (fixed priority or round-robin), per-requester write
// permission, one-cycle tagged read return and sticky illegal-access flags.
module cim_mem_arb #(
    parameter int                 DATA_W  = 16,
    parameter int                 DEPTH   = 528,
    parameter int                 N_REQ   = 4,
    parameter int                 RR_EN   = 0,
    parameter logic [N_REQ-1:0]   WR_MASK = 4'b1011,
    localparam int                ADDR_W  = $clog2(DEPTH),
    localparam int                ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_rd_req,
    input  logic [N_REQ-1:0]          i_wr_req,
    input  logic [N_REQ*ADDR_W-1:0]   i_addr,
    input  logic [N_REQ*DATA_W-1:0]   i_wr_data,
    output logic [N_REQ-1:0]          o_grant,
    output logic                      o_rd_valid,
    output logic [ID_W-1:0]           o_rd_id,
    output logic [DATA_W-1:0]         o_rd_data,
    output logic                      o_err_illegal_wr,
    output logic                      o_err_addr_oob,
    output logic                      o_err_rw_both
);

    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ-1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ID_W-1:0]   r_rr_ptr;

    logic [N_REQ-1:0]  w_wr_ok;
    logic [N_REQ-1:0]  w_req;
    logic [ID_W-1:0]   w_start;
    logic [ID_W-1:0]   w_idx;
    logic [ID_W-1:0]   w_j;
    logic              w_any;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_is_wr;
    logic              w_oob;
    logic              w_we;
    logic              w_rd;

    // Masked writes are dropped here, so they can never win arbitration.
    assign w_wr_ok = i_wr_req & WR_MASK;
    assign w_req   = i_rd_req | w_wr_ok;
    assign w_start = (RR_EN != 0) ? r_rr_ptr : '0;

    // Scan from the start index, wrapping; the lowest offset wins, so the
    // loop walks downward and the last hit is kept.
    always_comb begin
        int j;
        j     = 0;
        w_j   = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            j = int'(w_start) + k;
            if (j >= N_REQ) j = j - N_REQ;
            w_j = ID_W'(j);
            if (w_req[w_j]) begin
                w_any = 1'b1;
                w_idx = w_j;
            end
        end
    end

    // One-hot grant from the winning index.
    always_comb begin
        o_grant = '0;
        if (w_any) o_grant[w_idx] = 1'b1;
    end

    // A requester with both rd and wr set is a write only when permitted.
    assign w_addr  = i_addr[w_idx*ADDR_W +: ADDR_W];
    assign w_wdata = i_wr_data[w_idx*DATA_W +: DATA_W];
    assign w_is_wr = w_wr_ok[w_idx];
    assign w_oob   = ({1'b0, w_addr} >= DEPTH_L);
    assign w_we    = w_any & w_is_wr & ~w_oob;
    assign w_rd    = w_any & ~w_is_wr;

    // Storage write; suppressed while reset is held and for out-of-range addresses.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_we) r_mem[w_addr] <= w_wdata;
    end

    // Read return, arbitration pointer and sticky error flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rd_valid       <= 1'b0;
            o_rd_id          <= '0;
            o_rd_data        <= '0;
            r_rr_ptr         <= '0;
            o_err_illegal_wr <= 1'b0;
            o_err_addr_oob   <= 1'b0;
            o_err_rw_both    <= 1'b0;
        end else begin
            o_rd_valid <= w_rd;
            if (w_rd) begin
                o_rd_id   <= w_idx;
                o_rd_data <= w_oob ? '0 : r_mem[w_addr];
            end
            if (w_any) r_rr_ptr <= (w_idx == LAST_ID) ? '0 : w_idx + 1'b1;
            if (|(i_wr_req & ~WR_MASK))   o_err_illegal_wr <= 1'b1;
            if (w_any && w_oob)           o_err_addr_oob   <= 1'b1;
            if (|(i_rd_req & i_wr_req))   o_err_rw_both    <= 1'b1;
        end
    end

endmodule
